// File: rtl/ifetch_line_fill_if.sv
// Bundle of the fetch-side miss handshake, local-store read port and fill outputs.
interface ifetch_line_fill_if;
  logic          miss_req;
  logic [0:14]   miss_pc;
  logic          miss_rdy;
  logic          flush;
  logic          ls_rd_en;
  logic [0:14]   ls_rd_addr;
  logic          ls_rd_gnt;
  logic          ls_rd_valid;
  logic [0:127]  ls_rd_data;
  logic          fill_valid;
  logic [0:7]    fill_tag;
  logic [0:1023] fill_line;
  logic          busy;
  logic          proto_err;

  modport slave (
    input  miss_req, miss_pc, flush, ls_rd_gnt, ls_rd_valid, ls_rd_data,
    output miss_rdy, ls_rd_en, ls_rd_addr, fill_valid, fill_tag, fill_line, busy, proto_err
  );

  modport master (
    output miss_req, miss_pc, flush, ls_rd_gnt, ls_rd_valid, ls_rd_data,
    input  miss_rdy, ls_rd_en, ls_rd_addr, fill_valid, fill_tag, fill_line, busy, proto_err
  );
endinterface

// File: rtl/ifetch_line_fill.sv
// Instruction line-fill unit: fetches a 128-byte line as eight 16-byte beats from
// local store, assembles it, and hands it to fetch with a one-cycle fill pulse.
module ifetch_line_fill #(
  parameter int LINE_BEATS = 8,
  parameter int LS_MAX_OUT = 8
) (
  input logic              clk,
  input logic              rst_n,
  ifetch_line_fill_if.slave bus
);

  localparam logic [3:0] BEATS_C   = 4'(LINE_BEATS);
  localparam logic [3:0] LAST_C    = 4'(LINE_BEATS - 1);
  localparam logic [3:0] MAX_OUT_C = 4'(LS_MAX_OUT);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    issue_cnt_q, issue_cnt_d;
  logic [3:0]    rcv_cnt_q, rcv_cnt_d;
  logic [3:0]    outst_q, outst_d;
  logic [0:7]    tag_q, tag_d;
  logic [0:1023] line_q, line_d;
  logic          proto_err_q, proto_err_d;

  logic          rd_en;
  logic          issue_fire;
  logic          ret_take;
  logic          unsolicited;
  logic          beat_wr;
  logic [7:0]    beat_we;
  logic          pc_low_unused;

  // Only the line index of the PC matters; the offset within the line is dropped.
  assign pc_low_unused = ^bus.miss_pc[8:14];

  // Flush gates the request in the same cycle so no new read escapes during abort.
  assign rd_en = (state_q == FILL) && (issue_cnt_q < BEATS_C) &&
                 (outst_q < MAX_OUT_C) && !bus.flush;
  assign issue_fire  = rd_en && bus.ls_rd_gnt;
  assign ret_take    = bus.ls_rd_valid && (outst_q != 4'd0);
  assign unsolicited = bus.ls_rd_valid && (outst_q == 4'd0);
  assign beat_wr     = (state_q == FILL) && ret_take && !bus.flush;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_beat_we
      assign beat_we[gi] = beat_wr && (rcv_cnt_q[2:0] == 3'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    tag_d       = tag_q;
    line_d      = line_q;
    proto_err_d = proto_err_q | unsolicited;
    outst_d     = outst_q + {3'b000, issue_fire} - {3'b000, ret_take};

    for (int b = 0; b < 8; b++) begin
      if (beat_we[b]) begin
        line_d[128*b +: 128] = bus.ls_rd_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          state_d     = FILL;
          tag_d       = bus.miss_pc[0:7];
          issue_cnt_d = 4'd0;
          rcv_cnt_d   = 4'd0;
        end
      end
      FILL: begin
        if (issue_fire) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (beat_wr) begin
          rcv_cnt_d = rcv_cnt_q + 4'd1;
        end
        // A flush that coincides with the last outstanding return needs no drain.
        if (bus.flush) begin
          state_d = (outst_d == 4'd0) ? IDLE : DRAIN;
        end else if (beat_wr && (rcv_cnt_q == LAST_C)) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (outst_d == 4'd0) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= 4'd0;
      rcv_cnt_q   <= 4'd0;
      outst_q     <= 4'd0;
      tag_q       <= '0;
      line_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      outst_q     <= outst_d;
      tag_q       <= tag_d;
      line_q      <= line_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.miss_rdy   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.ls_rd_en   = rd_en;
  assign bus.ls_rd_addr = {tag_q, issue_cnt_q[2:0], 4'b0000};
  assign bus.fill_valid = (state_q == DONE) && !bus.flush;
  assign bus.fill_tag   = tag_q;
  assign bus.fill_line  = line_q;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_ifetch_line_fill.sv
// Directed bench for ifetch_line_fill with a small in-order local-store responder.
module tb_ifetch_line_fill;

  logic clk;
  logic rst_n;

  ifetch_line_fill_if bus ();

  ifetch_line_fill #(.LINE_BEATS(8), .LS_MAX_OUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [14:0] addr;
  } rd_t;

  rd_t         rq[$];
  logic [14:0] issued_log[$];
  int          cyc       = 0;
  int          lat       = 2;
  int          seed      = 0;
  int          hold_err  = 0;
  int          fill_cnt  = 0;
  bit          gnt_alt   = 1'b0;
  bit          gnt_cmd   = 1'b0;
  bit          force_valid = 1'b0;
  bit          prev_wait = 1'b0;
  logic [14:0] prev_addr = '0;

  function automatic logic [0:127] beat_data(input logic [14:0] addr, input int sd);
    logic [0:127] d;
    int k;
    k = (int'(addr) >> 4) & 7;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16*k + i + sd);
    return d;
  endfunction

  function automatic logic [0:1023] exp_line(input int sd);
    logic [0:1023] l;
    for (int n = 0; n < 128; n++) l[8*n +: 8] = 8'(n + sd);
    return l;
  endfunction

  // Local-store responder: drives grant/returns at the falling edge, in issue order.
  always @(negedge clk) begin
    if (!rst_n) begin
      rq.delete();
      bus.ls_rd_valid = 1'b0;
      bus.ls_rd_gnt   = 1'b0;
      bus.ls_rd_data  = '0;
      prev_wait       = 1'b0;
    end else begin
      bus.ls_rd_gnt = gnt_alt ? cyc[0] : gnt_cmd;
      if (prev_wait && bus.ls_rd_en && (bus.ls_rd_addr != prev_addr)) hold_err++;
      prev_wait = bus.ls_rd_en && !bus.ls_rd_gnt;
      prev_addr = bus.ls_rd_addr;
      if (bus.ls_rd_en && bus.ls_rd_gnt) begin
        rq.push_back('{cyc + lat, bus.ls_rd_addr});
        issued_log.push_back(bus.ls_rd_addr);
      end
      if (force_valid) begin
        bus.ls_rd_valid = 1'b1;
        bus.ls_rd_data  = {16{8'hA5}};
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        bus.ls_rd_valid = 1'b1;
        bus.ls_rd_data  = beat_data(rq[0].addr, seed);
        void'(rq.pop_front());
      end else begin
        bus.ls_rd_valid = 1'b0;
      end
      if (bus.fill_valid === 1'b1) fill_cnt++;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [14:0] pc);
    bus.miss_pc  = pc;
    bus.miss_req = 1'b1;
    step();
    bus.miss_req = 1'b0;
  endtask

  // Waits (bounded) for the fill pulse; n counts cycles since the accepting edge.
  task automatic run_fill(input logic [7:0] etag, input int sd, input int start_n,
                          input int exp_n, input string nm);
    int n;
    bit seen;
    n    = start_n;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      if (bus.fill_valid === 1'b1) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk({nm, "_seen"}, 1024'(seen), 1024'(1));
    if (seen) begin
      if (exp_n > 0) chk({nm, "_cycle"}, 1024'(n), 1024'(exp_n));
      chk({nm, "_tag"}, 1024'(bus.fill_tag), 1024'(etag));
      chk({nm, "_line"}, bus.fill_line, exp_line(sd));
      step();
      chk({nm, "_fv_low"}, 1024'(bus.fill_valid), 1024'(0));
      chk({nm, "_rdy"}, 1024'(bus.miss_rdy), 1024'(1));
    end
    $display("fill %s tag=%0h checks=%0d failures=%0d", nm, bus.fill_tag, checks, failures);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_miss_rdy"}, 1024'(bus.miss_rdy), 1024'(1));
    chk({nm, "_busy"}, 1024'(bus.busy), 1024'(0));
    chk({nm, "_rd_en"}, 1024'(bus.ls_rd_en), 1024'(0));
    chk({nm, "_rd_addr"}, 1024'(bus.ls_rd_addr), 1024'(0));
    chk({nm, "_fill_valid"}, 1024'(bus.fill_valid), 1024'(0));
    chk({nm, "_fill_tag"}, 1024'(bus.fill_tag), 1024'(0));
    chk({nm, "_fill_line"}, bus.fill_line, 1024'(0));
    chk({nm, "_proto_err"}, 1024'(bus.proto_err), 1024'(0));
  endtask

  initial begin
    int fc0;
    logic [0:1023] held;
    rst_n        = 1'b0;
    bus.miss_req = 1'b0;
    bus.miss_pc  = '0;
    bus.flush    = 1'b0;
    repeat (2) step();
    chk_reset_outputs("reset");
    $display("reset checks=%0d failures=%0d", checks, failures);
    rst_n = 1'b1;
    step();

    // Basic fill: PC 0x0A48, grant always, latency 2.
    seed = 0; lat = 2; gnt_cmd = 1'b1;
    accept(15'h0A48);
    for (int k = 0; k < 8; k++) begin
      chk("basic_en", 1024'(bus.ls_rd_en), 1024'(1));
      chk("basic_addr", 1024'(bus.ls_rd_addr), 1024'(15'h0A00 + 15'(16*k)));
      step();
    end
    run_fill(8'h14, 0, 9, 11, "basic");

    // Grant on alternate cycles, latency 1.
    gnt_alt = 1'b1; lat = 1; hold_err = 0;
    issued_log.delete();
    accept(15'h0A48);
    run_fill(8'h14, 0, 1, -1, "backpressure");
    gnt_alt = 1'b0;
    chk("bp_issue_count", 1024'(issued_log.size()), 1024'(8));
    for (int k = 0; k < 8; k++) begin
      chk("bp_issue_addr", 1024'(issued_log[k]), 1024'(15'h0A00 + 15'(16*k)));
    end
    chk("bp_addr_hold", 1024'(hold_err), 1024'(0));

    // Flush after 3 issues and 1 return, latency 4; two returns drain afterwards.
    lat = 4; gnt_cmd = 1'b0; fc0 = fill_cnt;
    accept(15'h0A48);
    gnt_cmd = 1'b1; step();
    gnt_cmd = 1'b0; step();
    gnt_cmd = 1'b1; step();
    gnt_cmd = 1'b1; step();
    gnt_cmd = 1'b0; step();
    chk("flush_en_before", 1024'(bus.ls_rd_en), 1024'(1));
    bus.flush = 1'b1;
    #1;
    chk("flush_en_gated", 1024'(bus.ls_rd_en), 1024'(0));
    step();
    bus.flush = 1'b0;
    chk("drain_busy", 1024'(bus.busy), 1024'(1));
    step();
    chk("drain_rdy_low", 1024'(bus.miss_rdy), 1024'(0));
    step();
    chk("drain_rdy_high", 1024'(bus.miss_rdy), 1024'(1));
    chk("drain_no_fill", 1024'(fill_cnt), 1024'(fc0));
    chk("drain_proto_err", 1024'(bus.proto_err), 1024'(0));
    chk("drain_ls_empty", 1024'(rq.size()), 1024'(0));
    $display("flush_mid checks=%0d failures=%0d", checks, failures);

    // Flush during the DONE cycle (latency 1: DONE at cycle 10).
    seed = 0; lat = 1; gnt_cmd = 1'b1; fc0 = fill_cnt;
    accept(15'h0A48);
    repeat (9) step();
    chk("done_fv_before", 1024'(bus.fill_valid), 1024'(1));
    bus.flush = 1'b1;
    #1;
    chk("done_fv_flushed", 1024'(bus.fill_valid), 1024'(0));
    step();
    bus.flush = 1'b0;
    chk("done_rdy", 1024'(bus.miss_rdy), 1024'(1));
    chk("done_no_fill", 1024'(fill_cnt), 1024'(fc0));
    seed = 5;
    accept(15'h1F00);
    run_fill(8'h3E, 5, 1, 10, "refill");

    // Unsolicited return while idle.
    held = bus.fill_line;
    force_valid = 1'b1;
    step();
    force_valid = 1'b0;
    chk("unsol_proto_err", 1024'(bus.proto_err), 1024'(1));
    chk("unsol_line_kept", bus.fill_line, exp_line(5));
    chk("unsol_line_same", bus.fill_line, held);
    chk("unsol_rdy", 1024'(bus.miss_rdy), 1024'(1));
    repeat (2) step();
    chk("unsol_sticky", 1024'(bus.proto_err), 1024'(1));
    $display("unsolicited proto_err=%0b checks=%0d failures=%0d", bus.proto_err, checks, failures);

    // Asynchronous reset after five beats have returned (latency 3).
    seed = 3; lat = 3; gnt_cmd = 1'b1;
    accept(15'h0A48);
    repeat (8) step();
    chk("pre_reset_busy", 1024'(bus.busy), 1024'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    step();
    rst_n = 1'b1;
    step();
    seed = 9; lat = 2;
    accept(15'h1F00);
    run_fill(8'h3E, 9, 1, 11, "post_reset");
    chk("post_reset_proto_err", 1024'(bus.proto_err), 1024'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
